serial_out: RTL and testbench

Parallel-to-serial transmitter for the dataset RAM. It is the counterpart of the serial receiver that loads the RAM. On `start` it reads words 0..`num_dp` from a synchronous RAM and shifts each word out on `ser`, one bit per clock. The active window of each word is bits `DATA_WIDTH-16*(feat+1)` up to `DATA_WIDTH-1`, sent in increasing index order. This is exactly the framing the receiver expects, so the two blocks form a loopback pair for dataset upload and readback.

---
 rtl/minor_pkg.sv | 13 +
 rtl/serial_out_if.sv | 20 ++
 rtl/serial_out.sv | 120 ++++++++++++
 tb/tb_serial_out.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/minor_pkg.sv
// minor_pkg: shared dataset RAM geometry, FSM states and frame framing helper
package minor_pkg;
    localparam int LENGTH       = 16;
    localparam int MAX_FEATURES = 15;
    localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int ADDR_WIDTH   = 12;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

    function automatic logic [8:0] frame_start(input logic [3:0] f);
        return 9'(DATA_WIDTH - LENGTH) - {1'b0, f, 4'b0};
    endfunction
endpackage

// File: rtl/serial_out_if.sv
// serial_out_if: control, RAM read port and serial stream of the transmitter
interface serial_out_if;
    import minor_pkg::*;
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_dp;
    logic [3:0]            feat;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ser;
    logic                  ser_valid;
    logic                  last;
    logic                  busy;
    logic                  done;

    modport master (input start, num_dp, feat, rd_data,
                    output rd_en, addr, ser, ser_valid, last, busy, done);
    modport slave  (output start, num_dp, feat, rd_data,
                    input rd_en, addr, ser, ser_valid, last, busy, done);
endinterface

// File: rtl/serial_out.sv
// serial_out: streams RAM words 0..num_dp out one frame bit per clock
module serial_out
    import minor_pkg::*;
(
    input logic          CLK,
    input logic          RST,
    serial_out_if.master bus
);
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] sh, pbuf;
    logic [7:0]            i, fs;
    logic [12:0]           k;
    logic [ADDR_WIDTH-1:0] nd, addr_n;
    logic [3:0]            fe;
    logic                  pf, go, more, more2, wend;
    logic                  rd_en_n, ser_n, sv_n, last_n, busy_n, done_n;

    assign fs    = 8'(frame_start(fe));
    assign go    = (state == IDLE || state == DONE) && bus.start;
    assign more  = k < {1'b0, nd};
    assign more2 = k + 13'd1 < {1'b0, nd};
    assign wend  = state == SHIFT && i == 8'd255;

    // next state and next registered outputs; i is the index of the bit now on ser
    always_comb begin
        state_n = state;
        rd_en_n = 1'b0;
        addr_n  = bus.addr;
        ser_n   = 1'b0;
        sv_n    = 1'b0;
        last_n  = 1'b0;
        busy_n  = bus.busy;
        done_n  = bus.done;
        case (state)
            IDLE, DONE: if (bus.start) begin
                state_n = FETCH;
                rd_en_n = 1'b1;
                addr_n  = '0;
                busy_n  = 1'b1;
                done_n  = 1'b0;
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                state_n = SHIFT;
                ser_n   = bus.rd_data[fs];
                sv_n    = 1'b1;
                rd_en_n = more;
                addr_n  = more ? ADDR_WIDTH'(k + 13'd1) : bus.addr;
            end
            SHIFT: if (!wend) begin
                ser_n  = sh[i + 8'd1];
                sv_n   = 1'b1;
                last_n = i == 8'd254 && !more;
            end else if (more) begin
                ser_n   = pbuf[fs];
                sv_n    = 1'b1;
                rd_en_n = more2;
                addr_n  = more2 ? ADDR_WIDTH'(k + 13'd2) : bus.addr;
            end else begin
                state_n = DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            bus.rd_en     <= 1'b0;
            bus.addr      <= '0;
            bus.ser       <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.last      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            bus.rd_en     <= rd_en_n;
            bus.addr      <= addr_n;
            bus.ser       <= ser_n;
            bus.ser_valid <= sv_n;
            bus.last      <= last_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
        end
    end

    // shift register, prefetch buffer, bit index and word counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            k  <= '0;
            i  <= '0;
            nd <= '0;
            fe <= '0;
            pf <= 1'b0;
        end else begin
            pf <= bus.rd_en;
            if (pf) pbuf <= bus.rd_data;
            if (go) begin
                nd <= bus.num_dp;
                fe <= bus.feat;
                k  <= '0;
            end
            if (state == LOAD) begin
                sh <= bus.rd_data;
                i  <= fs;
            end else if (state == SHIFT) begin
                if (!wend) i <= i + 8'd1;
                else if (more) begin
                    sh <= pbuf;
                    i  <= fs;
                    k  <= k + 13'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_out.sv
// tb_serial_out: directed checks of framing, timing, prefetch, abort and restart
`define CHK(tag, o, e) begin checks++; assert ((o) === (e)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, o, e); end end
module tb_serial_out;
    logic CLK, RST;
    serial_out_if bus();
    serial_out dut (.CLK(CLK), .RST(RST), .bus(bus));

    logic [255:0] mem [0:4095];
    logic [255:0] rx  [0:4095];
    int rdcnt [0:4095];
    int checks = 0, errors = 0;
    int cyc = 0, T = 0, rc;
    logic mon_clr = 1'b1;
    logic [7:0] mon_fs = 8'd240, rxp;
    int vcnt, bursts, first_v, last_v, last_n, last_c, done_c, busy_f, busy_l;
    int rd_count, ser_bad, rxw;
    logic [11:0] first_addr, last_addr;
    logic pv, pd, seen_busy;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cycle counter: value k after the k-th rising edge
    always @(posedge CLK) cyc++;

    // synchronous RAM model
    always @(posedge CLK) if (bus.rd_en) bus.rd_data <= mem[bus.addr];

    // stream monitor: rebuilds received words and records timing
    always @(negedge CLK) begin
        if (mon_clr) begin
            vcnt = 0; bursts = 0; first_v = 0; last_v = 0; last_n = 0; last_c = 0;
            done_c = 0; busy_f = 0; busy_l = 0; rd_count = 0; ser_bad = 0;
            rxw = 0; rxp = mon_fs; pv = 1'b0; pd = bus.done; seen_busy = 1'b0;
            first_addr = '0; last_addr = '0;
            for (int a = 0; a < 4096; a++) rdcnt[a] = 0;
        end else begin
            if (bus.ser_valid) begin
                if (!pv) bursts++;
                if (vcnt == 0) first_v = cyc + 1;
                last_v = cyc + 1;
                vcnt++;
                rx[rxw][rxp] = bus.ser;
                if (rxp == 8'd255) begin rxw++; rxp = mon_fs; end
                else rxp++;
            end else if (bus.ser) ser_bad++;
            pv = bus.ser_valid;
            if (bus.last) begin last_n++; last_c = cyc + 1; end
            if (bus.done && !pd) done_c = cyc + 1;
            pd = bus.done;
            if (bus.busy) begin
                if (!seen_busy) busy_f = cyc + 1;
                seen_busy = 1'b1;
                busy_l = cyc + 1;
            end
            if (bus.rd_en) begin
                if (rd_count == 0) first_addr = bus.addr;
                rd_count++;
                rdcnt[bus.addr]++;
                last_addr = bus.addr;
            end
        end
    end

    function automatic int mism(input int nw, input int lo);
        int n = 0;
        for (int w = 0; w < nw; w++) if (((rx[w] ^ mem[w]) >> lo) != 0) n++;
        return n;
    endfunction

    task automatic step;
        @(negedge CLK);
        #1;
    endtask

    task automatic go(input int nd, input int ft);
        bus.num_dp = 12'(nd);
        bus.feat   = 4'(ft);
        mon_fs     = 8'(240 - 16 * ft);
        mon_clr    = 1'b1;
        step;
        mon_clr    = 1'b0;
        bus.start  = 1'b1;
        T          = cyc + 1;
        step;
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin step; n++; end
        `CHK("done_reached", bus.done, 1'b1)
    endtask

    task automatic wait_v(input int target, input int budget);
        int n = 0;
        while (vcnt < target && n < budget) begin step; n++; end
        `CHK("valid_reached", vcnt, target)
    endtask

    initial begin
        for (int w = 0; w < 4096; w++)
            for (int j = 0; j < 8; j++) mem[w][j*32 +: 32] = $urandom;
        mem[0][255:240] = 16'hA5C3;
        RST = 1'b1; bus.start = 1'b0; bus.num_dp = '0; bus.feat = '0;
        repeat (3) step;
        `CHK("rst_rd_en", bus.rd_en, 1'b0)
        `CHK("rst_addr", bus.addr, 12'd0)
        `CHK("rst_ser", bus.ser, 1'b0)
        `CHK("rst_ser_valid", bus.ser_valid, 1'b0)
        `CHK("rst_last", bus.last, 1'b0)
        `CHK("rst_busy", bus.busy, 1'b0)
        `CHK("rst_done", bus.done, 1'b0)
        RST = 1'b0;
        step;

        go(0, 0);
        wait_done(100);
        `CHK("min_field", rx[0][255:240], 16'hA5C3)
        `CHK("min_vcnt", vcnt, 16)
        `CHK("min_first_bit", first_v, T + 3)
        `CHK("min_last_bit", last_v, T + 18)
        `CHK("min_last_cyc", last_c, T + 18)
        `CHK("min_last_cnt", last_n, 1)
        `CHK("min_done_cyc", done_c, T + 19)
        `CHK("min_busy_first", busy_f, T + 1)
        `CHK("min_busy_last", busy_l, T + 18)
        `CHK("min_reads", rd_count, 1)
        `CHK("min_ser_idle", ser_bad, 0)

        go(2, 15);
        wait_done(1000);
        `CHK("full_vcnt", vcnt, 768)
        `CHK("full_bursts", bursts, 1)
        `CHK("full_data", mism(3, 0), 0)
        `CHK("full_reads", rd_count, 3)
        `CHK("full_rd0", rdcnt[0], 1)
        `CHK("full_rd1", rdcnt[1], 1)
        `CHK("full_rd2", rdcnt[2], 1)
        `CHK("full_last_cyc", last_c, T + 770)
        `CHK("full_done_cyc", done_c, T + 771)
        `CHK("full_busy_last", busy_l, T + 770)
        `CHK("full_ser_idle", ser_bad, 0)

        go(5, 7);
        wait_done(1000);
        `CHK("loop_vcnt", vcnt, 768)
        `CHK("loop_data", mism(6, 128), 0)
        `CHK("loop_reads", rd_count, 6)

        go(2, 15);
        wait_v(357, 1000);
        RST = 1'b1;
        step;
        `CHK("abort_ser_valid", bus.ser_valid, 1'b0)
        `CHK("abort_busy", bus.busy, 1'b0)
        `CHK("abort_rd_en", bus.rd_en, 1'b0)
        RST = 1'b0;
        rc = rd_count;
        repeat (5) step;
        `CHK("abort_no_reads", rd_count, rc)
        `CHK("abort_idle_done", bus.done, 1'b0)
        go(2, 15);
        wait_done(1000);
        `CHK("replay_first_addr", first_addr, 12'd0)
        `CHK("replay_vcnt", vcnt, 768)
        `CHK("replay_data", mism(3, 0), 0)

        go(1, 3);
        wait_v(40, 200);
        bus.num_dp = 12'd3; bus.feat = 4'd0; bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        wait_done(500);
        `CHK("ign_vcnt", vcnt, 128)
        `CHK("ign_reads", rd_count, 2)
        `CHK("ign_data", mism(2, 192), 0)
        go(3, 0);
        wait_done(500);
        `CHK("new_vcnt", vcnt, 64)
        `CHK("new_reads", rd_count, 4)
        `CHK("new_data", mism(4, 240), 0)

        go(4095, 0);
        wait_done(70000);
        `CHK("big_vcnt", vcnt, 65536)
        `CHK("big_bursts", bursts, 1)
        `CHK("big_reads", rd_count, 4096)
        `CHK("big_last_addr", last_addr, 12'd4095)
        `CHK("big_rd0", rdcnt[0], 1)
        `CHK("big_data", mism(4096, 240), 0)
        `CHK("big_done_cyc", done_c, T + 65539)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
